// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/MULH/DIV/REM sequencer: radix-2 shift-add / restoring divide on magnitudes, sign fixed at the end.
// Latency: XLEN+1 stall cycles for normal ops (accept + XLEN iterations), 1 for divide-by-zero / overflow.
// Backpressure: stall_o freezes the front end until done_o; start_i is ignored while running and in DONE.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNTW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  // Multiply: full product accumulator (multiplier shifts out the bottom).
  // Divide: low half holds the dividend shifting into the quotient.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     rem_q, rem_d;   // divide partial remainder
  logic [XLEN-1:0]     opd_q, opd_d;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]     res_q, res_d;

  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_zero, div_ovf;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_acc, prod_s;
  logic [XLEN:0]       div_shift, div_diff;
  logic                div_ge;
  logic [XLEN-1:0]     div_quo, div_rem, quo_s, rem_s, fixed_res;

  // One iteration of each datapath plus the final sign correction.
  always_comb begin
    mag_a     = src_a_i[XLEN-1] ? -src_a_i : src_a_i;
    mag_b     = src_b_i[XLEN-1] ? -src_b_i : src_b_i;
    div_zero  = (src_b_i == '0);
    div_ovf   = (src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (src_b_i == '1);

    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mul_acc   = {mul_sum, acc_q[XLEN-1:1]};

    // Partial remainder is always below the divisor, so bit XLEN of the
    // difference is a reliable borrow flag.
    div_shift = {rem_q, acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opd_q};
    div_ge    = ~div_diff[XLEN];
    div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    div_quo   = {acc_q[XLEN-2:0], div_ge};

    prod_s    = (sign_a_q ^ sign_b_q) ? -mul_acc : mul_acc;
    quo_s     = (sign_a_q ^ sign_b_q) ? -div_quo : div_quo;
    rem_s     = sign_a_q ? -div_rem : div_rem;

    case (op_q)
      2'b00:   fixed_res = prod_s[XLEN-1:0];
      2'b01:   fixed_res = prod_s[2*XLEN-1:XLEN];
      2'b10:   fixed_res = quo_s;
      default: fixed_res = rem_s;
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opd_d    = opd_q;
    res_d    = res_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d     = op_i;
          sign_a_d = src_a_i[XLEN-1];
          sign_b_d = src_b_i[XLEN-1];
          cnt_d    = '0;
          rem_d    = '0;
          opd_d    = op_i[1] ? mag_b : mag_a;
          acc_d    = {{XLEN{1'b0}}, (op_i[1] ? mag_a : mag_b)};
          if (op_i[1] && div_zero) begin
            res_d   = op_i[0] ? src_a_i : '1;
            state_d = S_DONE;
          end else if (op_i[1] && div_ovf) begin
            res_d   = op_i[0] ? '0 : src_a_i;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNTW'(1);
        if (op_q[1]) begin
          acc_d = {acc_q[2*XLEN-1:XLEN], div_quo};
          rem_d = div_rem;
        end else begin
          acc_d = mul_acc;
        end
        if (cnt_q == CNTW'(XLEN-1)) begin
          res_d   = fixed_res;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      rem_q    <= '0;
      opd_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opd_q    <= opd_d;
      res_q    <= res_d;
    end
  end

  assign busy_o   = (state_q == S_RUN);
  assign done_o   = (state_q == S_DONE);
  assign stall_o  = ((state_q == S_IDLE) && start_i) || (state_q == S_RUN);
  assign result_o = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed cases plus randomized ops against an arithmetic reference.
// Latency: outputs compared every cycle against a cycle-count model.
// Backpressure: start held through each op; perturbed while running to show it is ignored.
module tb_muldiv_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src_a_i, src_b_i;
  logic        busy_o, stall_o, done_o;
  logic [31:0] result_o;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  int done_cnt = 0;

  // Reference model state: cycles of iteration left, done flag, visible result.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .op_i     (op_i),
    .src_a_i  (src_a_i),
    .src_b_i  (src_b_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[1] && ((b == 32'h0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: begin r = sa * sb; return r[31:0]; end
      2'b01: begin r = sa * sb; return r[63:32]; end
      2'b10: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        r = sa / sb;
        return r[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        r = sa % sb;
        return r[31:0];
      end
    endcase
  endfunction

  // Cycle-level reference: an accepted op finishes 32 edges later (or at once if special).
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_left = 0;
      m_done = 1'b0;
      m_res  = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_res  = m_pend;
      end
    end else if (start_i) begin
      if (ref_special(op_i, src_a_i, src_b_i)) begin
        m_done = 1'b1;
        m_res  = ref_result(op_i, src_a_i, src_b_i);
      end else begin
        m_left = 32;
        m_pend = ref_result(op_i, src_a_i, src_b_i);
      end
    end
  end

  // Per-cycle comparison of all outputs against the reference.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("cyc_busy",   32'(busy_o),  32'(m_left > 0));
      chk("cyc_stall",  32'(stall_o), 32'((m_left > 0) || (!m_done && start_i)));
      chk("cyc_done",   32'(done_o),  32'(m_done));
      chk("cyc_result", result_o,     m_res);
      if (done_o) done_cnt++;
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit perturb, output logic [31:0] res, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    res = '0;
    start_i = 1'b1;
    op_i = op;
    src_a_i = a;
    src_b_i = b;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i);
      if (stall_o) lat++;
      if (done_o) begin
        res = result_o;
        got = 1'b1;
        break;
      end
      @(posedge clk_i); #2;
      if (perturb && k >= 2 && k < 20) begin
        start_i = 1'($urandom_range(0, 1));
        src_a_i = $urandom;
        src_b_i = $urandom;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL op_timeout op=%0d actual=no_done required=done", op);
    end else begin
      @(posedge clk_i); #2;
    end
  endtask

  task automatic gap();
    start_i = 1'b0;
    @(posedge clk_i); #2;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r, a, b;
    logic [1:0]  op;
    int          l, d0;
    bit          pt;
    start_i = 1'b0;
    op_i = 2'b00;
    src_a_i = '0;
    src_b_i = '0;
    repeat (2) @(posedge clk_i);
    cmp_en = 1'b1;
    @(negedge clk_i);
    chk("rst_busy",   32'(busy_o),  32'h0);
    chk("rst_done",   32'(done_o),  32'h0);
    chk("rst_stall",  32'(stall_o), 32'h0);
    chk("rst_result", result_o,     32'h0);
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    @(posedge clk_i); #2;

    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0, r, l);
    chk("mul_7xm3", r, 32'hFFFF_FFEB);
    chk("mul_lat", 32'(l), 32'd33);
    gap();
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, r, l);
    chk("mulh_min2", r, 32'h4000_0000);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, r, l);
    chk("mul_min2", r, 32'h0);
    gap();
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, r, l);
    chk("div_m7_2", r, 32'hFFFF_FFFD);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, r, l);
    chk("rem_m7_2", r, 32'hFFFF_FFFF);
    gap();
    run_op(2'b10, 32'd5, 32'd0, 1'b0, r, l);
    chk("div_by0", r, 32'hFFFF_FFFF);
    chk("div_by0_lat", 32'(l), 32'd1);
    run_op(2'b11, 32'd5, 32'd0, 1'b0, r, l);
    chk("rem_by0", r, 32'd5);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r, l);
    chk("div_ovf", r, 32'h8000_0000);
    chk("div_ovf_lat", 32'(l), 32'd1);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r, l);
    chk("rem_ovf", r, 32'h0);
    gap();
    run_op(2'b10, 32'd100, 32'd7, 1'b1, r, l);
    chk("div_perturbed", r, 32'd14);
    chk("div_perturbed_lat", 32'(l), 32'd33);
    gap();

    // Abort at the tenth iteration, then restart.
    start_i = 1'b1;
    op_i = 2'b10;
    src_a_i = 32'd100;
    src_b_i = 32'd7;
    d0 = done_cnt;
    repeat (11) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("abort_result", result_o, 32'h0);
    chk("abort_busy", 32'(busy_o), 32'h0);
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'h0);
    @(posedge clk_i); #2;
    run_op(2'b10, 32'd100, 32'd7, 1'b0, r, l);
    chk("div_restart", r, 32'd14);
    gap();

    // Back-to-back with start held high across the two ops.
    d0 = done_cnt;
    run_op(2'b00, 32'd3, 32'd4, 1'b0, r, l);
    chk("b2b_mul", r, 32'd12);
    run_op(2'b10, 32'd12, 32'd5, 1'b0, r, l);
    chk("b2b_div", r, 32'd2);
    chk("b2b_div_lat", 32'(l), 32'd33);
    chk("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      pt = 1'($urandom_range(0, 3) == 0);
      run_op(op, a, b, pt, r, l);
      chk("rnd_result", r, ref_result(op, a, b));
      chk("rnd_lat", 32'(l), ref_special(op, a, b) ? 32'd1 : 32'd33);
      if ($urandom_range(0, 1) == 1) gap();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
